// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the LED counter run/pause/step/clear controller.
// State encodings are plain 3-bit constants so external tools can decode them.
package counter_ctrl_pkg;

  localparam logic [2:0] PAUSE    = 3'd0;
  localparam logic [2:0] RUN      = 3'd1;
  localparam logic [2:0] HOLD_P   = 3'd2;
  localparam logic [2:0] HOLD_R   = 3'd3;
  localparam logic [2:0] CLR_WAIT = 3'd4;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, mismatch-count debounce and
// registered one-cycle press/release pulses taken from the stable level.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic released
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      level    <= 1'b0;
      level_d  <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      level_d  <= level;
      press    <= level & ~level_d;
      released <= ~level & level_d;
      // Any sample agreeing with the stable level restarts the count.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/step/clear controller driving the LED counter's cnt_en/cnt_clr.
// Short press toggles run/pause, long press clears, step advances when paused.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DB_CYCLES   = 500000,
  parameter int LONG_CYCLES = 100000000,
  parameter int TICK_DIV    = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  input  logic step,
  output logic cnt_en,
  output logic cnt_clr,
  output logic running
);

  localparam int HW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = '1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_n;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_n;
  logic          clr_n;
  logic          en_n;
  logic          run_active;
  logic          tick;

  logic btn_level, btn_press, btn_release;
  logic stp_level, stp_press, stp_release;
  logic unused_levels;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_button_db (
    .clock    (clock),
    .reset    (reset),
    .raw      (button),
    .level    (btn_level),
    .press    (btn_press),
    .released (btn_release)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clock    (clock),
    .reset    (reset),
    .raw      (step),
    .level    (stp_level),
    .press    (stp_press),
    .released (stp_release)
  );

  assign unused_levels = ^{btn_level, stp_level, stp_release};

  assign run_active = (state == RUN) || (state == HOLD_R);
  assign tick       = run_active && (presc == TICK_LAST);

  // Prescaler is parked at zero outside the running states so a resume
  // always waits a full period before the first advance.
  always_comb begin
    presc_n = '0;
    if (run_active && !tick) presc_n = presc + 1'b1;
  end

  // Steps are honoured only in PAUSE; elsewhere they are simply dropped.
  assign en_n = tick || (stp_press && (state == PAUSE));

  always_comb begin
    state_n = state;
    hold_n  = hold;
    clr_n   = 1'b0;
    case (state)
      PAUSE: begin
        if (btn_press) begin
          state_n = HOLD_P;
          hold_n  = '0;
        end
      end
      RUN: begin
        if (btn_press) begin
          state_n = HOLD_R;
          hold_n  = '0;
        end
      end
      HOLD_P, HOLD_R: begin
        if (hold != HOLD_MAX) hold_n = hold + 1'b1;
        if (hold >= HOLD_LAST) begin
          // A release landing on the threshold itself skips the wait state.
          clr_n   = 1'b1;
          state_n = btn_release ? PAUSE : CLR_WAIT;
        end else if (btn_release) begin
          state_n = (state == HOLD_P) ? RUN : PAUSE;
        end
      end
      CLR_WAIT: begin
        if (btn_release) state_n = PAUSE;
      end
      default: state_n = PAUSE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= PAUSE;
      hold    <= '0;
      presc   <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      hold    <= hold_n;
      presc   <= presc_n;
      cnt_en  <= en_n;
      cnt_clr <= clr_n;
      running <= (state_n == RUN) || (state_n == HOLD_R);
    end
  end

endmodule
